// File: rtl/pipe_add_pkg.sv
// Shared helpers for the pipelined adder: operand width, slice width and
// a legality check on the (S, P) parameter pair.
package pipe_add_pkg;

  // Operand width W = 2**S.
  function automatic int pa_width(input int s);
    return 32'sd1 << s;
  endfunction

  // Bits handled by each pipeline stage.
  function automatic int pa_slice_width(input int w, input int p);
    return w / p;
  endfunction

  // P must be a power of two between 1 and W inclusive.
  function automatic bit pa_params_legal(input int s, input int p);
    int w;
    w = pa_width(s);
    return (p >= 32'sd1) && (p <= w) && ((p & (p - 32'sd1)) == 32'sd0);
  endfunction

endpackage

// File: rtl/pipe_add_stage.sv
// One pipeline stage: adds slice K of the operands using the carry handed
// over by the previous stage, and registers the beat (valid, operands, sub,
// carry, partial result, overflow) when the pipeline advances.
module pipe_add_stage
  import pipe_add_pkg::*;
#(
  parameter int W  = 8,
  parameter int SW = 4,
  parameter int K  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         adv,
  input  logic         in_valid,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_sub,
  input  logic         in_carry,
  input  logic [W-1:0] in_s,
  output logic         out_valid,
  output logic [W-1:0] out_a,
  output logic [W-1:0] out_b,
  output logic         out_sub,
  output logic         out_carry,
  output logic [W-1:0] out_s,
  output logic         out_ovf
);

  localparam int LO = K * SW;

  logic [SW-1:0] a_sl_s;
  logic [SW-1:0] bx_sl_s;
  logic [SW:0]   sum_s;
  logic          msb_cin_s;
  logic [W-1:0]  res_s;

  logic          valid_q, valid_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          sub_q, sub_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  s_q, s_d;
  logic          ovf_q, ovf_d;

  // Slice adder; the carry into the slice MSB is recovered from the MSB sum bit.
  always_comb begin
    a_sl_s    = in_a[LO +: SW];
    bx_sl_s   = in_b[LO +: SW] ^ {SW{in_sub}};
    sum_s     = {1'b0, a_sl_s} + {1'b0, bx_sl_s} + {{SW{1'b0}}, in_carry};
    msb_cin_s = sum_s[SW-1] ^ a_sl_s[SW-1] ^ bx_sl_s[SW-1];
    res_s            = in_s;
    res_s[LO +: SW]  = sum_s[SW-1:0];
  end

  // Next-state: load the incoming beat on advance, otherwise hold.
  always_comb begin
    if (adv) begin
      valid_d = in_valid;
      a_d     = in_a;
      b_d     = in_b;
      sub_d   = in_sub;
      carry_d = sum_s[SW];
      s_d     = res_s;
      ovf_d   = msb_cin_s ^ sum_s[SW];
    end else begin
      valid_d = valid_q;
      a_d     = a_q;
      b_d     = b_q;
      sub_d   = sub_q;
      carry_d = carry_q;
      s_d     = s_q;
      ovf_d   = ovf_q;
    end
  end

  // Stage registers with synchronous active-low clear.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      carry_q <= 1'b0;
      s_q     <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      carry_q <= carry_d;
      s_q     <= s_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_a     = a_q;
  assign out_b     = b_q;
  assign out_sub   = sub_q;
  assign out_carry = carry_q;
  assign out_s     = s_q;
  assign out_ovf   = ovf_q;

endmodule

// File: rtl/pipe_add.sv
// Pipelined W-bit adder/subtractor split into P carry-chained stages with a
// single global advance signal for valid/ready flow control.
module pipe_add
  import pipe_add_pkg::*;
#(
  parameter  int S = 3,
  parameter  int P = 2,
  localparam int W = pa_width(S)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf
);

  localparam int SW = pa_slice_width(W, P);

  if (!pa_params_legal(S, P)) begin : g_bad_params
    $error("pipe_add: P must be a power of two with 1 <= P <= 2**S");
  end

  logic              adv_s;
  logic [P:0]        valid_c;
  logic [P:0]        sub_c;
  logic [P:0]        carry_c;
  logic [P:0][W-1:0] a_c;
  logic [P:0][W-1:0] b_c;
  logic [P:0][W-1:0] s_c;
  logic [P-1:0]      ovf_c;
  logic              unused_s;

  // The whole pipeline moves when the output slot is empty or being drained.
  always_comb begin
    adv_s    = ~valid_c[P] | out_ready;
    in_ready = adv_s & rst_n;
  end

  // Stage 0 inputs come straight from the ports; subtraction forces carry-in.
  assign valid_c[0] = in_valid;
  assign a_c[0]     = a;
  assign b_c[0]     = b;
  assign sub_c[0]   = sub;
  assign carry_c[0] = cin | sub;
  assign s_c[0]     = '0;

  for (genvar k = 0; k < P; k++) begin : g_stage
    pipe_add_stage #(
      .W  (W),
      .SW (SW),
      .K  (k)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .adv       (adv_s),
      .in_valid  (valid_c[k]),
      .in_a      (a_c[k]),
      .in_b      (b_c[k]),
      .in_sub    (sub_c[k]),
      .in_carry  (carry_c[k]),
      .in_s      (s_c[k]),
      .out_valid (valid_c[k+1]),
      .out_a     (a_c[k+1]),
      .out_b     (b_c[k+1]),
      .out_sub   (sub_c[k+1]),
      .out_carry (carry_c[k+1]),
      .out_s     (s_c[k+1]),
      .out_ovf   (ovf_c[k])
    );
  end

  // Outputs are taken directly from the last stage's registers.
  assign out_valid = valid_c[P];
  assign s         = s_c[P];
  assign cout      = carry_c[P];
  assign ovf       = ovf_c[P-1];

  // Operand copies leaving the last stage and early-stage overflow are dead ends.
  assign unused_s = ^{a_c[P], b_c[P], sub_c[P], ovf_c};

endmodule

// File: tb/tb_pipe_add.sv
// Self-checking bench for pipe_add: directed vector table and corner-case
// sequences on an S=3/P=2 instance, plus random streams on several configs.
module tb_pipe_add;

  localparam int NCFG  = 6;
  localparam int NBEAT = 150;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] es;
    logic       ec;
    logic       eo;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  s;
  logic        cout;
  logic        ovf;

  int          n_cmp;
  int          n_bad;
  logic [33:0] cur_exp;
  logic [33:0] sb_q[$];
  logic        start_rand;
  wire  [NCFG-1:0] gdone;
  vec_t        vt[12];

  function automatic int cfg_s(int g);
    case (g)
      0: return 0;
      1: return 3;
      2: return 3;
      3: return 3;
      4: return 5;
      default: return 5;
    endcase
  endfunction

  function automatic int cfg_p(int g);
    case (g)
      0: return 1;
      1: return 1;
      2: return 2;
      3: return 8;
      4: return 2;
      default: return 32;
    endcase
  endfunction

  // Reference: {cout, ovf, s} for a w-bit add/sub, arithmetic on 33 bits.
  function automatic logic [33:0] ref_model(int w, logic [31:0] ra, logic [31:0] rb,
                                            logic rc, logic rs);
    logic [32:0] mask, m1, bx, c, sum, lo;
    logic        cim;
    mask = (33'd1 << w) - 33'd1;
    m1   = mask >> 1;
    bx   = (rs ? ~{1'b0, rb} : {1'b0, rb}) & mask;
    c    = {32'd0, rc | rs};
    sum  = ({1'b0, ra} & mask) + bx + c;
    lo   = ({1'b0, ra} & m1) + (bx & m1) + c;
    cim  = lo[w-1];
    return {sum[w], cim ^ sum[w], sum[31:0] & mask[31:0]};
  endfunction

  task automatic chk(input string nm, input logic [33:0] got, input logic [33:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask

  pipe_add #(.S(3), .P(2)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard for the directed instance: pop on deliver, push on accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("stale_result", {cout, ovf, 24'd0, s}, 34'h3FFFFFFFF);
        end else begin
          chk("result", {cout, ovf, 24'd0, s}, sb_q.pop_front());
        end
      end
      if (in_valid && in_ready) sb_q.push_back(cur_exp);
    end
  end

  // Drive one beat from the posedge+1 phase and wait (bounded) until accepted.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                      input logic ts, input logic [33:0] te);
    int   t;
    logic acc;
    a = ta; b = tb_v; cin = tc; sub = ts; cur_exp = te; in_valid = 1'b1;
    t = 0; acc = 1'b0;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!acc) chk("send_timeout", 34'(in_ready), 34'd1);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 100) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (sb_q.size() != 0) chk("drain", 34'(sb_q.size()), 34'd0);
  endtask

  // Random streams across several (S, P) configurations.
  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int GS = cfg_s(g);
    localparam int GP = cfg_p(g);
    localparam int GW = 1 << GS;

    logic          rv, rrdy, oval, ordy, rcin, rsub, oc, oo, done;
    logic [GW-1:0] ra, rb, os;
    logic [33:0]   gexp;
    logic [33:0]   gq[$];

    pipe_add #(.S(GS), .P(GP)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (rv),
      .in_ready  (rrdy),
      .a         (ra),
      .b         (rb),
      .cin       (rcin),
      .sub       (rsub),
      .out_valid (oval),
      .out_ready (ordy),
      .s         (os),
      .cout      (oc),
      .ovf       (oo)
    );

    assign gdone[g] = done;

    // Stimulus with random bubbles.
    initial begin : drv
      int   t;
      logic acc;
      done = 1'b0; rv = 1'b0; ra = '0; rb = '0; rcin = 1'b0; rsub = 1'b0; gexp = '0;
      wait (start_rand);
      @(posedge clk);
      #1;
      for (int i = 0; i < NBEAT; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          rv = 1'b0;
          @(posedge clk);
          #1;
        end else begin
          ra   = GW'($urandom);
          rb   = GW'($urandom);
          rcin = 1'($urandom);
          rsub = 1'($urandom);
          gexp = ref_model(GW, 32'(ra), 32'(rb), rcin, rsub);
          rv   = 1'b1;
          t = 0; acc = 1'b0;
          while (!acc && t < 100) begin
            @(negedge clk);
            acc = rrdy;
            @(posedge clk);
            #1;
            t++;
          end
          if (!acc) chk($sformatf("rand_timeout_S%0d_P%0d", GS, GP), 34'(rrdy), 34'd1);
        end
      end
      rv = 1'b0;
      t = 0;
      while (gq.size() != 0 && t < 300) begin
        @(posedge clk);
        #1;
        t++;
      end
      if (gq.size() != 0) chk($sformatf("rand_drain_S%0d_P%0d", GS, GP), 34'(gq.size()), 34'd0);
      done = 1'b1;
    end

    // Random downstream backpressure.
    initial begin
      ordy = 1'b1;
      wait (start_rand);
      while (!done) begin
        @(posedge clk);
        #1;
        ordy = ($urandom_range(0, 3) != 0);
      end
      ordy = 1'b1;
    end

    // Per-config scoreboard.
    always @(negedge clk) begin
      if (!rst_n) begin
        gq.delete();
      end else begin
        if (oval && ordy) begin
          if (gq.size() == 0) begin
            chk($sformatf("rand_stale_S%0d_P%0d", GS, GP), {oc, oo, 32'(os)}, 34'h3FFFFFFFF);
          end else begin
            chk($sformatf("rand_S%0d_P%0d", GS, GP), {oc, oo, 32'(os)}, gq.pop_front());
          end
        end
        if (rv && rrdy) gq.push_back(gexp);
      end
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int t;
    n_cmp = 0; n_bad = 0; start_rand = 1'b0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0; cur_exp = '0;

    vt[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
    vt[1]  = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0};
    vt[2]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
    vt[3]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
    vt[4]  = '{8'h10, 8'h20, 1'b1, 1'b0, 8'h31, 1'b0, 1'b0};
    vt[5]  = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
    vt[6]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
    vt[7]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0};
    vt[8]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};
    vt[9]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
    vt[10] = '{8'h3C, 8'h5A, 1'b0, 1'b1, 8'hE2, 1'b0, 1'b0};
    vt[11] = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 34'(in_ready), 34'd0);
    chk("rst_out_valid", 34'(out_valid), 34'd0);
    chk("rst_outputs", {cout, ovf, 24'd0, s}, 34'd0);
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", 34'(in_ready), 34'd1);

    // Latency: accepted at edge n, visible after edge n+1.
    send(8'h12, 8'h34, 1'b0, 1'b0, {2'b00, 24'd0, 8'h46});
    in_valid = 1'b0;
    chk("latency_not_yet", 34'(out_valid), 34'd0);
    @(posedge clk);
    #1;
    chk("latency_valid", 34'(out_valid), 34'd1);
    chk("latency_data", {cout, ovf, 24'd0, s}, {2'b00, 24'd0, 8'h46});
    drain();

    // Table vectors back to back.
    for (int i = 0; i < 12; i++) begin
      send(vt[i].a, vt[i].b, vt[i].cin, vt[i].sub, {vt[i].ec, vt[i].eo, 24'd0, vt[i].es});
    end
    in_valid = 1'b0;
    drain();

    // Backpressure: output stalls for 3 cycles with beats waiting.
    out_ready = 1'b0;
    send(8'h01, 8'h02, 1'b0, 1'b0, {2'b00, 24'd0, 8'h03});
    send(8'h10, 8'h20, 1'b0, 1'b0, {2'b00, 24'd0, 8'h30});
    a = 8'hAA; b = 8'h0A; cin = 1'b0; sub = 1'b1; cur_exp = {2'b10, 24'd0, 8'hA0};
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("stall_in_ready", 34'(in_ready), 34'd0);
      chk("stall_hold", {out_valid, cout, ovf, 23'd0, s}, {1'b1, 2'b00, 23'd0, 8'h03});
    end
    out_ready = 1'b1;
    send(8'hAA, 8'h0A, 1'b0, 1'b1, {2'b10, 24'd0, 8'hA0});
    send(8'hC8, 8'h64, 1'b0, 1'b0, {2'b10, 24'd0, 8'h2C});
    in_valid = 1'b0;
    drain();

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(8'h11, 8'h22, 1'b0, 1'b0, {2'b00, 24'd0, 8'h33});
    send(8'h44, 8'h55, 1'b0, 1'b0, {2'b00, 24'd0, 8'h99});
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", 34'(in_ready), 34'd0);
    chk("midrst_out_valid", 34'(out_valid), 34'd0);
    chk("midrst_outputs", {cout, ovf, 24'd0, s}, 34'd0);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_stale", 34'(out_valid), 34'd0);
    end

    // Random streams on all configurations.
    start_rand = 1'b1;
    t = 0;
    while (gdone != {NCFG{1'b1}} && t < 30000) begin
      @(posedge clk);
      t++;
    end
    if (gdone != {NCFG{1'b1}}) chk("rand_done", 34'(gdone), 34'((1 << NCFG) - 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
